sine_seq: RTL and testbench

SINE_SEQ -- requirements
Module: sine_seq

---
 rtl/sine_seq_if.sv | 35 +++
 rtl/sine_seq.sv | 148 ++++++++++++++
 tb/tb_sine_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_seq_if.sv
// sine_seq_if: request/response handshake and CORDIC core link for sine_seq.
// The slave modport is the sequencer's view; master is the surrounding system.
// Mode_i exists only when SINE_SEQ_COS_EN is defined.
interface sine_seq_if;
`ifdef SINE_SEQ_COS_EN
  logic        Mode_i;
`endif
  logic [15:0] Phase_i;
  logic        Valid_i;
  logic        Ready_o;
  logic [15:0] Result_o;
  logic        Valid_o;
  logic        Ready_i;
  logic        Err_o;
  logic [15:0] Cordic_Angle_o;
  logic        Cordic_Start_o;
  logic [15:0] Cordic_Sine_i;
  logic        Cordic_Done_i;

  modport slave (
`ifdef SINE_SEQ_COS_EN
    input  Mode_i,
`endif
    input  Phase_i, Valid_i, Ready_i, Cordic_Sine_i, Cordic_Done_i,
    output Ready_o, Result_o, Valid_o, Err_o, Cordic_Angle_o, Cordic_Start_o
  );

  modport master (
`ifdef SINE_SEQ_COS_EN
    output Mode_i,
`endif
    output Phase_i, Valid_i, Ready_i, Cordic_Sine_i, Cordic_Done_i,
    input  Ready_o, Result_o, Valid_o, Err_o, Cordic_Angle_o, Cordic_Start_o
  );
endinterface

// File: rtl/sine_seq.sv
// sine_seq: folds a 16-bit binary angle into the CORDIC convergence range,
// converts it to Q3.12 radians, launches the core with a one-cycle start
// pulse and returns the core's sine over a valid/ready handshake. A core
// that never produces a fresh done edge is cut off after TIMEOUT WAIT cycles
// with a zero result and Err_o set.
// Optional feature macro: SINE_SEQ_COS_EN (adds Mode_i; Mode_i=1 yields cosine).
module sine_seq #(
  parameter int TIMEOUT = 24
) (
  input logic       Clk_i,
  input logic       Rst_i,
  sine_seq_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REDUCE, LAUNCH, WAIT, HOLD} state_t;

  state_t state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] angle_q, angle_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        done_q;

  logic [15:0]        phaseIn;
  logic               accept;
  logic               doneEvt;
  logic [CW-1:0]      cntInc;
  logic signed [16:0] sPhase;
  logic signed [16:0] sFold;
  logic signed [33:0] prod;
  logic [15:0]        angleCalc;

`ifdef SINE_SEQ_COS_EN
  assign phaseIn = bus.Phase_i + (bus.Mode_i ? 16'd16384 : 16'd0);
`else
  assign phaseIn = bus.Phase_i;
`endif

  assign accept  = bus.Valid_i & ready_q;
  assign doneEvt = bus.Cordic_Done_i & ~done_q;
  assign cntInc  = cnt_q + CW'(1);

  // Mirror angles beyond +/- a quarter turn back into range, then scale
  // binary angle to Q3.12 radians (25736 = pi * 2^13, shifted down by 16).
  always_comb begin
    sPhase = 17'($signed(phase_q));
    if (sPhase > 17'sd16384)
      sFold = 17'sd32768 - sPhase;
    else if (sPhase < -17'sd16384)
      sFold = -17'sd32768 - sPhase;
    else
      sFold = sPhase;
    prod      = 34'(sFold) * 34'sd25736;
    angleCalc = 16'(prod >>> 16);
  end

  // Sequencer next-state and register updates; everything holds by default.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    angle_d  = angle_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = err_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          phase_d = phaseIn;
          err_d   = 1'b0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        angle_d = angleCalc;
        start_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cntInc;
        if (doneEvt) begin
          result_d = bus.Cordic_Sine_i;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (cntInc == CW'(TIMEOUT)) begin
          result_d = '0;
          err_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.Ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset forces IDLE with every output low.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      angle_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      angle_q  <= angle_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      done_q   <= bus.Cordic_Done_i;
    end
  end

  assign bus.Ready_o        = ready_q;
  assign bus.Result_o       = result_q;
  assign bus.Valid_o        = valid_q;
  assign bus.Err_o          = err_q;
  assign bus.Cordic_Angle_o = angle_q;
  assign bus.Cordic_Start_o = start_q;

endmodule

// File: tb/tb_sine_seq.sv
// tb_sine_seq: randomized and directed bench for sine_seq. A timeline model
// (edge indices relative to acceptance) predicts every output each cycle;
// directed cases pin angles, latency, timeout and reset behaviour.
module tb_sine_seq;

  localparam int TIMEOUT = 24;

  logic Clk_i;
  logic Rst_i;
  sine_seq_if bus();

  sine_seq #(.TIMEOUT(TIMEOUT)) dut (
    .Clk_i(Clk_i),
    .Rst_i(Rst_i),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state: expected outputs and the acceptance timeline.
  int          cyc = 0;
  int          accEdge = 0;
  bit          mBusy = 0;
  bit          mHold = 0;
  bit          prevDone = 0;
  bit          evt;
  logic [15:0] mPhase = '0;
  logic        expReady = 0, expValid = 0, expErr = 0, expStart = 0;
  logic [15:0] expAngle = '0, expResult = '0;

  // Free-running clock.
  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: fold by the quadrant rule, then scale to Q3.12 radians.
  function automatic logic [15:0] refAngle(input logic [15:0] ph);
    int s;
    s = int'($signed(ph));
    if (s > 16384) s = 32768 - s;
    else if (s < -16384) s = -32768 - s;
    return 16'((s * 25736) >>> 16);
  endfunction

  // Timeline model: start one edge after acceptance, WAIT from the second,
  // WAIT cycle k ends at edge accEdge+2+k; done edge wins over timeout.
  always @(posedge Clk_i) begin
    cyc++;
    if (Rst_i) begin
      mBusy = 0; mHold = 0; prevDone = 0;
      expReady = 0; expValid = 0; expErr = 0; expStart = 0;
      expAngle = '0; expResult = '0;
    end else begin
      evt = bus.Cordic_Done_i && !prevDone;
      prevDone = bus.Cordic_Done_i;
      expStart = 0;
      if (mHold) begin
        if (bus.Ready_i) begin
          mHold = 0; expValid = 0; expReady = 1;
        end
      end else if (mBusy) begin
        if (cyc == accEdge + 1) begin
          expAngle = refAngle(mPhase);
          expStart = 1;
        end else if (cyc >= accEdge + 3) begin
          if (evt) begin
            expResult = bus.Cordic_Sine_i; expErr = 0; expValid = 1;
            mBusy = 0; mHold = 1;
          end else if (cyc == accEdge + 2 + TIMEOUT) begin
            expResult = '0; expErr = 1; expValid = 1;
            mBusy = 0; mHold = 1;
          end
        end
      end else if (expReady && bus.Valid_i) begin
        mBusy = 1; accEdge = cyc; expErr = 0; expReady = 0;
`ifdef SINE_SEQ_COS_EN
        mPhase = bus.Phase_i + (bus.Mode_i ? 16'd16384 : 16'd0);
`else
        mPhase = bus.Phase_i;
`endif
      end else begin
        expReady = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge Clk_i) begin
    #1;
    if (Rst_i) begin
      checkOutput("rst Ready_o", 32'(bus.Ready_o), 0);
      checkOutput("rst Valid_o", 32'(bus.Valid_o), 0);
      checkOutput("rst Err_o", 32'(bus.Err_o), 0);
      checkOutput("rst Start", 32'(bus.Cordic_Start_o), 0);
      checkOutput("rst Angle", 32'(bus.Cordic_Angle_o), 0);
      checkOutput("rst Result", 32'(bus.Result_o), 0);
    end else begin
      checkOutput("Ready_o", 32'(bus.Ready_o), 32'(expReady));
      checkOutput("Valid_o", 32'(bus.Valid_o), 32'(expValid));
      checkOutput("Err_o", 32'(bus.Err_o), 32'(expErr));
      checkOutput("Start", 32'(bus.Cordic_Start_o), 32'(expStart));
      checkOutput("Angle", 32'(bus.Cordic_Angle_o), 32'(expAngle));
      if (expValid) checkOutput("Result", 32'(bus.Result_o), 32'(expResult));
    end
  end

  // One transaction: accept, answer the start pulse as a core would
  // (done rises `delay` cycles later, or never when stuck), then hold.
  task automatic applyStimulus(input logic [15:0] phase, input logic mode, input int delay,
                               input bit stuck, input logic [15:0] sine, input int hold,
                               input int angleLit);
    int n;
    bit seen;
    bit wantErr;
    wantErr = stuck || (delay > TIMEOUT);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge Clk_i);
      if (bus.Ready_o) seen = 1;
    end
    if (!seen) begin
      checkOutput("ready wait", 32'(bus.Ready_o), 1);
      return;
    end
    bus.Valid_i = 1'b1;
    bus.Phase_i = phase;
`ifdef SINE_SEQ_COS_EN
    bus.Mode_i = mode;
`else
    if (mode) bus.Phase_i = phase;
`endif
    @(negedge Clk_i);
    bus.Valid_i = 1'b0;
    checkOutput("err cleared at accept", 32'(bus.Err_o), 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk_i);
      if (bus.Cordic_Start_o) seen = 1;
    end
    if (!seen) begin
      checkOutput("start wait", 32'(bus.Cordic_Start_o), 1);
      return;
    end
    if (angleLit >= 0) checkOutput("angle literal", 32'(bus.Cordic_Angle_o), 32'(angleLit));
    if (!stuck) bus.Cordic_Done_i = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n <= TIMEOUT + 5) begin
      @(negedge Clk_i);
      n++;
      if (bus.Valid_o) begin
        seen = 1;
        bus.Valid_i = 1'b0;
      end else begin
        bus.Valid_i = 1'($urandom_range(0, 1));
        bus.Phase_i = 16'($urandom);
        if (!stuck && n == delay) begin
          bus.Cordic_Done_i = 1'b1;
          bus.Cordic_Sine_i = sine;
        end
      end
    end
    if (!seen) begin
      checkOutput("valid wait", 32'(bus.Valid_o), 1);
      return;
    end
    checkOutput("latency", 32'(n), wantErr ? 32'(TIMEOUT + 1) : 32'(delay + 1));
    checkOutput("err flag", 32'(bus.Err_o), 32'(wantErr));
    checkOutput("result", 32'(bus.Result_o), wantErr ? 32'd0 : 32'(sine));
    for (int h = 0; h < hold; h++) begin
      bus.Ready_i = 1'b0;
      bus.Valid_i = 1'($urandom_range(0, 1));
      @(negedge Clk_i);
      checkOutput("hold valid", 32'(bus.Valid_o), 1);
    end
    bus.Valid_i = 1'b0;
    bus.Ready_i = 1'b1;
    @(negedge Clk_i);
    bus.Ready_i = 1'b0;
    checkOutput("idle after release", 32'(bus.Ready_o), 1);
    checkOutput("valid dropped", 32'(bus.Valid_o), 0);
  endtask

  // Directed cases, mid-WAIT reset, then a randomized run.
  initial begin
    bit sawValid;
    int tmo;
    Rst_i = 1'b1;
    bus.Phase_i = '0; bus.Valid_i = 0; bus.Ready_i = 0;
    bus.Cordic_Sine_i = '0; bus.Cordic_Done_i = 0;
`ifdef SINE_SEQ_COS_EN
    bus.Mode_i = 0;
`endif
    repeat (3) @(negedge Clk_i);
    Rst_i = 1'b0;
    @(negedge Clk_i);
    checkOutput("ready after reset", 32'(bus.Ready_o), 1);

    applyStimulus(16'h4000, 0, 5, 0, 16'h1000, 0, 16'h1922);
    applyStimulus(16'h6000, 0, 3, 0, 16'h0B50, 1, 16'h0C91);
    applyStimulus(16'hC000, 0, 7, 0, 16'hF000, 0, 16'hE6DE);
    applyStimulus(16'h8000, 0, 1, 0, 16'h0000, 2, 16'h0000);
    // Done is still high from the last op: no fresh edge, so timeout.
    applyStimulus(16'h1234, 0, 3, 1, 16'h5555, 0, -1);
    applyStimulus(16'h2000, 0, TIMEOUT, 0, 16'h2D41, 0, -1);
    applyStimulus(16'hE000, 0, TIMEOUT + 1, 0, 16'h1111, 0, -1);
    applyStimulus(16'h0800, 0, 4, 0, 16'h0C8B, 10, -1);

    // Reset in the middle of WAIT; a later done edge must be ignored.
    tmo = 0;
    while (!bus.Ready_o && tmo < 50) begin @(negedge Clk_i); tmo++; end
    bus.Valid_i = 1; bus.Phase_i = 16'h2000;
    @(negedge Clk_i);
    bus.Valid_i = 0;
    tmo = 0;
    while (!bus.Cordic_Start_o && tmo < 10) begin @(negedge Clk_i); tmo++; end
    bus.Cordic_Done_i = 0;
    repeat (3) @(negedge Clk_i);
    Rst_i = 1'b1;
    #1;
    checkOutput("mid reset Valid_o", 32'(bus.Valid_o), 0);
    checkOutput("mid reset Ready_o", 32'(bus.Ready_o), 0);
    checkOutput("mid reset Angle", 32'(bus.Cordic_Angle_o), 0);
    checkOutput("mid reset Result", 32'(bus.Result_o), 0);
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b0;
    repeat (2) @(negedge Clk_i);
    bus.Cordic_Done_i = 1; bus.Cordic_Sine_i = 16'h7777;
    sawValid = 0;
    repeat (30) begin
      @(negedge Clk_i);
      if (bus.Valid_o) sawValid = 1;
    end
    checkOutput("no valid after reset", 32'(sawValid), 0);

`ifdef SINE_SEQ_COS_EN
    applyStimulus(16'h0000, 1, 6, 0, 16'h1000, 0, 16'h1922);
`endif

    for (int t = 0; t < 40; t++) begin
      applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, 28)),
                    ($urandom_range(0, 9) == 0), 16'($urandom), int'($urandom_range(0, 4)), -1);
    end

    repeat (2) @(negedge Clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so a wedged DUT still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
